// File: rtl/rangefinder_sopc_gpio_bidir.sv
// Avalon-MM bidirectional PIO: per-bit direction, optional open-drain drive,
// synchronised inputs, edge capture with write-1-to-clear and a maskable level irq.
module rangefinder_sopc_gpio_bidir #(
  parameter int unsigned      WIDTH       = 8,
  parameter int unsigned      SYNC_STAGES = 2,
  parameter int unsigned      OPEN_DRAIN  = 1,
  parameter int unsigned      EDGE_TYPE   = 2,
  parameter logic [WIDTH-1:0] RESET_OUT   = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic             irq,
  inout  wire  [WIDTH-1:0] bidir_port
);

  typedef enum logic [2:0] {
    REG_DATA   = 3'd0,
    REG_DIR    = 3'd1,
    REG_MASK   = 3'd2,
    REG_EDGE   = 3'd3,
    REG_OUTSET = 3'd4,
    REG_OUTCLR = 3'd5
  } reg_addr_e;

  logic [WIDTH-1:0] data_out;
  logic [WIDTH-1:0] dir;
  logic [WIDTH-1:0] mask;
  logic [WIDTH-1:0] edge_capture;
  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] prev;
  logic [WIDTH-1:0] sync_in;
  logic [WIDTH-1:0] wd;
  logic [WIDTH-1:0] edge_det;
  logic [WIDTH-1:0] edge_clr;
  logic [31:0]      rd_mux;
  logic             wr;

  assign wr      = chipselect & ~write_n;
  assign wd      = writedata[WIDTH-1:0];
  assign sync_in = sync_q[SYNC_STAGES-1];

  // Upper write-data bits are deliberately ignored when WIDTH < 32.
  generate
    if (WIDTH < 32) begin : g_unused_wd
      logic unused_wd;
      assign unused_wd = ^writedata[31:WIDTH];
    end
  endgenerate

  // Pin drivers: open-drain only ever pulls low, push-pull drives both levels.
  generate
    for (genvar i = 0; i < WIDTH; i++) begin : g_pin
      if (OPEN_DRAIN != 0) begin : g_od
        assign bidir_port[i] = (dir[i] & ~data_out[i]) ? 1'b0 : 1'bz;
      end else begin : g_pp
        assign bidir_port[i] = dir[i] ? data_out[i] : 1'bz;
      end
    end
  endgenerate

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    edge_det = '0;
    case (EDGE_TYPE)
      0:       edge_det = sync_in & ~prev;
      1:       edge_det = ~sync_in & prev;
      default: edge_det = sync_in ^ prev;
    endcase
  end

  assign edge_clr = (wr && address == REG_EDGE) ? wd : '0;

  always_comb begin
    rd_mux = '0;
    case (address)
      REG_DATA: rd_mux[WIDTH-1:0] = sync_in;
      REG_DIR:  rd_mux[WIDTH-1:0] = dir;
      REG_MASK: rd_mux[WIDTH-1:0] = mask;
      REG_EDGE: rd_mux[WIDTH-1:0] = edge_capture;
      default:  rd_mux = '0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_out     <= RESET_OUT;
      dir          <= '0;
      mask         <= '0;
      edge_capture <= '0;
      prev         <= '0;
      readdata     <= '0;
      irq          <= 1'b0;
      // NOTE: the synchroniser array is reset too, otherwise spurious edges
      // would be captured from power-up contents.
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
    end else begin
      sync_q[0] <= bidir_port;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
      prev <= sync_in;

      // A new edge wins over a simultaneous write-1-to-clear.
      edge_capture <= (edge_capture & ~edge_clr) | edge_det;
      irq          <= |(edge_capture & mask);
      readdata     <= rd_mux;

      if (wr) begin
        case (address)
          REG_DATA:   data_out <= wd;
          REG_DIR:    dir      <= wd;
          REG_MASK:   mask     <= wd;
          REG_OUTSET: data_out <= data_out | wd;
          REG_OUTCLR: data_out <= data_out & ~wd;
          default:    ;
        endcase
      end
    end
  end

endmodule
